// File: rtl/flash_dma_pkg.sv
// rtl/flash_dma_pkg.sv - shared types and constants for the flash-to-RAM DMA block
package flash_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        CMD,
        READ,
        WSETUP,
        WSTROBE,
        WHOLD,
        RELEASE
    } state_t;

    localparam logic [3:0] REG_SRC0 = 4'd0;
    localparam logic [3:0] REG_SRC1 = 4'd1;
    localparam logic [3:0] REG_SRC2 = 4'd2;
    localparam logic [3:0] REG_DST0 = 4'd3;
    localparam logic [3:0] REG_DST1 = 4'd4;
    localparam logic [3:0] REG_DST2 = 4'd5;
    localparam logic [3:0] REG_LEN0 = 4'd6;
    localparam logic [3:0] REG_LEN1 = 4'd7;
    localparam logic [3:0] REG_CTRL = 4'd8;

    localparam logic [7:0] SPI_READ_OP = 8'h03;

    // Clocks spent in GRANT so the 6502 has let go of the bus before SPI starts.
    localparam int GRANT_HOLD = 2;

endpackage

// File: rtl/flash_dma_if.sv
// rtl/flash_dma_if.sv - register, SPI flash and RAM bus signal bundle
// slave  : the DMA block (drives reg_rdata, SPI outputs, RAM bus, irq)
// master : the surrounding system (drives register strobes and flash_so)
interface flash_dma_if;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        flash_so;
    logic        flash_si;
    logic        flash_sck;
    logic        flash_cs_n;
    logic [18:0] address;
    logic [7:0]  data;
    logic        rw;
    logic        busen;
    logic        irq;

    modport slave (
        input  reg_we, reg_addr, reg_wdata, flash_so,
        output reg_rdata, flash_si, flash_sck, flash_cs_n,
        output address, data, rw, busen, irq
    );

    modport master (
        output reg_we, reg_addr, reg_wdata, flash_so,
        input  reg_rdata, flash_si, flash_sck, flash_cs_n,
        input  address, data, rw, busen, irq
    );
endinterface

// File: rtl/flash_dma_spi_shifter.sv
// rtl/flash_dma_spi_shifter.sv - SPI mode 0 bit engine, MSB first, 2 clocks per bit
// Ports: clock, reset_n; start/wide/tx load a 32-bit (wide=1) or 8-bit frame;
// so in; sck, si out; done is high during the final clock of a frame; rx is the
// last 8 bits received.
module spi_shifter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        wide,
    input  logic [31:0] tx,
    input  logic        so,
    output logic        sck,
    output logic        si,
    output logic        done,
    output logic [7:0]  rx
);

    logic [31:0] sh;
    logic [5:0]  cnt;
    logic        phase;
    logic        active;
    logic [7:0]  rx_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh     <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
            active <= 1'b0;
            rx_q   <= '0;
        end else if (start) begin
            // Narrow frames are left-aligned so si is always sh[31].
            sh     <= wide ? tx : {tx[7:0], 24'h0};
            cnt    <= wide ? 6'd32 : 6'd8;
            phase  <= 1'b0;
            active <= 1'b1;
        end else if (active) begin
            if (!phase) begin
                phase <= 1'b1;
            end else begin
                // End of the SCK=1 clock: sample so and advance to the next bit.
                phase <= 1'b0;
                sh    <= {sh[30:0], 1'b0};
                rx_q  <= {rx_q[6:0], so};
                cnt   <= cnt - 6'd1;
                if (cnt == 6'd1) begin
                    active <= 1'b0;
                end
            end
        end
    end

    assign sck  = active & phase;
    assign si   = active & sh[31];
    assign done = active & phase & (cnt == 6'd1);
    assign rx   = rx_q;

endmodule

// File: rtl/flash_dma.sv
// rtl/flash_dma.sv - copies LEN+1 bytes from SPI flash into 6502 RAM
// Ports: clock, reset_n (async, active-low); bus (flash_dma_if.slave) carries
// the register port (reg_we/reg_addr/reg_wdata/reg_rdata), the SPI flash pins
// (flash_so/si/sck/cs_n), the RAM bus (address/data/rw), busen and irq.
module flash_dma
    import flash_dma_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    flash_dma_if.slave  bus
);

    state_t      state;
    state_t      state_next;

    logic [7:0]  regs [0:7];
    logic [23:0] src_q;
    logic [18:0] dst_q;
    logic [15:0] len_q;
    logic [15:0] offset;
    logic [1:0]  grant_cnt;
    logic        irq_q;

    logic        busy;
    logic        ctrl_we;
    logic        start_req;
    logic        in_write;
    logic [18:0] wr_addr;

    logic        sh_start;
    logic        sh_wide;
    logic [31:0] sh_tx;
    logic        sh_done;
    logic [7:0]  sh_rx;
    logic        sh_sck;
    logic        sh_si;

    assign busy      = (state != IDLE);
    assign ctrl_we   = bus.reg_we && (bus.reg_addr == REG_CTRL);
    assign start_req = ctrl_we && bus.reg_wdata[0] && !busy;
    assign in_write  = (state == WSETUP) || (state == WSTROBE) || (state == WHOLD);
    assign wr_addr   = dst_q + {3'b000, offset};

    spi_shifter u_spi (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (sh_start),
        .wide    (sh_wide),
        .tx      (sh_tx),
        .so      (bus.flash_so),
        .sck     (sh_sck),
        .si      (sh_si),
        .done    (sh_done),
        .rx      (sh_rx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sh_start   = 1'b0;
        sh_wide    = 1'b0;
        sh_tx      = 32'h0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (grant_cnt == 2'(GRANT_HOLD - 1)) begin
                    state_next = CMD;
                    sh_start   = 1'b1;
                    sh_wide    = 1'b1;
                    sh_tx      = {SPI_READ_OP, src_q};
                end
            end
            CMD: begin
                // Reload for the first data byte on the last command clock,
                // so cs_n never deasserts between command and data.
                if (sh_done) begin
                    state_next = READ;
                    sh_start   = 1'b1;
                end
            end
            READ: begin
                if (sh_done) begin
                    state_next = WSETUP;
                end
            end
            WSETUP:  state_next = WSTROBE;
            WSTROBE: state_next = WHOLD;
            WHOLD: begin
                if (offset == len_q) begin
                    state_next = RELEASE;
                end else begin
                    state_next = READ;
                    sh_start   = 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            offset    <= '0;
            grant_cnt <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (bus.reg_we && !busy && !bus.reg_addr[3]) begin
                if (bus.reg_addr == REG_DST2) begin
                    regs[bus.reg_addr[2:0]] <= {5'b0, bus.reg_wdata[2:0]};
                end else begin
                    regs[bus.reg_addr[2:0]] <= bus.reg_wdata;
                end
            end

            // Completion outranks a same-clock clear so a finished transfer is never lost.
            if (state == RELEASE) begin
                irq_q <= 1'b1;
            end else if (ctrl_we && bus.reg_wdata[1]) begin
                irq_q <= 1'b0;
            end

            if (start_req) begin
                src_q     <= {regs[2], regs[1], regs[0]};
                dst_q     <= {regs[5][2:0], regs[4], regs[3]};
                len_q     <= {regs[7], regs[6]};
                offset    <= '0;
                grant_cnt <= '0;
            end else if (state == GRANT) begin
                grant_cnt <= grant_cnt + 2'd1;
            end

            if ((state == WHOLD) && (offset != len_q)) begin
                offset <= offset + 16'd1;
            end
        end
    end

    always_comb begin
        bus.reg_rdata = 8'h00;
        if (bus.reg_addr == REG_CTRL) begin
            bus.reg_rdata = {6'b0, irq_q, busy};
        end else if (!bus.reg_addr[3]) begin
            bus.reg_rdata = regs[bus.reg_addr[2:0]];
        end
    end

    assign bus.flash_cs_n = !((state == CMD) || (state == READ) || in_write);
    assign bus.flash_sck  = sh_sck;
    assign bus.flash_si   = sh_si;
    assign bus.address    = in_write ? wr_addr : 19'h0;
    assign bus.data       = in_write ? sh_rx : 8'h00;
    assign bus.rw         = (state != WSTROBE);
    assign bus.busen      = (state == IDLE);
    assign bus.irq        = irq_q;

endmodule

// File: doc/flash_dma.md
FLASH_DMA -- requirements
Module: flash_dma

Interface
REQ-001 SHALL have port clock  in  1  system clock (8 MHz nominal); single clock domain.
REQ-002 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port reg_we  in  1  register write strobe, one clock per write.
REQ-004 SHALL have port reg_addr  in  4  register index.
REQ-005 SHALL have port reg_wdata  in  8  register write data.
REQ-006 SHALL have port reg_rdata  out  8  register read data, combinational from reg_addr.
REQ-007 SHALL have ports flash_so in 1, flash_si out 1, flash_sck out 1, flash_cs_n out 1: SPI flash, mode 0, MSB first.
REQ-008 SHALL have ports address out 19, data out 8, rw out 1 (0 = RAM write): RAM bus, valid only while busen=0.
REQ-009 SHALL have port busen  out  1  1 = 6502 owns bus, 0 = DMA owns bus.
REQ-010 SHALL have port irq  out  1  completion interrupt, level, high until cleared.

Function
REQ-011 Registers SHALL be: 0-2 SRC[23:0] (LSB first); 3-5 DST[18:0] (reg 5 bits [2:0] only); 6-7 LEN[15:0]; 8 CTRL.
REQ-012 Byte count SHALL be LEN+1 (1..65536).
REQ-013 CTRL write: bit0=1 starts a transfer; bit1=1 clears irq; both bits in one write clear irq first, then start.
REQ-014 CTRL read SHALL return {6'b0, irq, busy}; registers 0-7 SHALL read back their stored value.
REQ-015 Writes to registers 0-7 and the start bit SHALL be ignored while busy=1; the irq clear bit SHALL always act.
REQ-016 States SHALL be IDLE, GRANT, CMD, READ, WSETUP, WSTROBE, WHOLD, RELEASE.
REQ-017 IDLE -> GRANT on start: busy=1, busen=0; GRANT SHALL hold 2 clocks before SPI activity (6502 releases bus).
REQ-018 CMD SHALL assert flash_cs_n=0 and shift 32 bits: 0x03 followed by SRC[23:0].
REQ-019 Each SPI bit SHALL take 2 clocks: SCK=0 with SI valid, then SCK=1; SO sampled at the end of the SCK=1 clock; one byte = 16 clocks.
REQ-020 READ SHALL shift in 8 bits, then go to WSETUP.
REQ-021 WSETUP SHALL drive address=DST+offset (mod 2^19) and data=received byte with rw=1.
REQ-022 WSTROBE SHALL drive rw=0 for exactly 1 clock, with address and data held.
REQ-023 WHOLD SHALL return rw=1 with address and data held, then go to READ if more bytes remain, else RELEASE.
REQ-024 flash_cs_n SHALL stay 0 from the first CMD bit to RELEASE (one continuous read command).
REQ-025 RELEASE SHALL set flash_cs_n=1, sck=0, si=0, address=0, data=0, busen=1, busy=0, irq=1, then go to IDLE.
REQ-026 Per-byte cost SHALL be 16+3 = 19 clocks.
REQ-027 Total clocks from the start write to busen=1 SHALL be 2+64+19*(LEN+1)+1.
REQ-028 The DST offset counter SHALL be 16 bits; address SHALL wrap 0x7FFFF -> 0x00000 silently.
REQ-029 SRC SHALL not be incremented by the block; the flash auto-increments and wraps at its own capacity.
REQ-030 The internal register copy used for the transfer SHALL be latched at start; later register writes SHALL not affect a running transfer.

Reset
REQ-031 Asserting reset_n=0 SHALL immediately force: state IDLE, flash_cs_n=1, flash_sck=0, flash_si=0, address=0, data=0, rw=1, busen=1, irq=0, busy=0, all registers 0.
REQ-032 Reset mid-transfer SHALL abort the transfer with no further RAM write; the bus returns to the 6502 in the same clock.
REQ-033 After reset_n release, the first start SHALL behave identically to a cold start.

Structure
REQ-034 A shared package SHALL hold the state enum, register index constants (SRC0..CTRL), the SPI read opcode 0x03, and the GRANT hold length (2).
REQ-035 One sub-module, spi_shifter, SHALL implement the SPI bit engine: load width 8/32, 2-clock bit, done pulse, received byte out.
REQ-036 flash_dma SHALL hold the registers, FSM, and RAM bus drive.

Verification
REQ-037 SRC=0x080000, DST=0x0E000, LEN=3, start with flash model holding AA 55 01 FE -> SI carries 03 08 00 00; four rw=0 pulses at 0x0E000..0x0E003 with data AA,55,01,FE; busen=1 and irq=1 after 2+64+76+1 clocks.
REQ-038 DST=0x7FFFE, LEN=2 -> writes at 0x7FFFE, 0x7FFFF, 0x00000.
REQ-039 During busy, write LEN=0xFF and CTRL=1 -> readback unchanged, transfer length unchanged; CTRL=2 during busy -> irq stays 0 until RELEASE, then 1.
REQ-040 reset_n=0 pulse during the 2nd byte's READ -> within the same clock busen=1, flash_cs_n=1, rw=1; no further rw=0 pulses; CTRL reads 0x00.
REQ-041 LEN=0 -> exactly one RAM write; CTRL write 0x03 after completion -> irq clears and a new transfer starts (busy=1 next clock).
REQ-042 A rw=0 pulse SHALL last exactly 1 clock, with address and data stable 1 clock before and 1 clock after; busen=0 throughout every transfer.
